feature_requantizer: RTL and testbench
======================================

Name: feature_requantizer

Overview:
- Streaming post-processing stage directly downstream of the CNN accelerator core.
- Consumes the wide signed feature stream (m_axis_features), applies a per-output-channel fixed-point scale, rounds, shifts and saturates to a narrow activation width, and optionally applies ReLU.
- Its output feeds the next layer's s_axis_activations input.
- Per-channel scales are written through a simple register-write port driven by the AXI-Lite control decoder.

Parameters:
- IN_WIDTH, 32, width of signed input feature word.
- OUT_WIDTH, 8, width of signed output activation.
- SCALE_WIDTH, 16, width of signed per-channel scale.
- SHIFT, 16, right-shift applied after multiply; range 1..IN_WIDTH+SCALE_WIDTH-1.
- OC, 128, number of output channels; channel index cycles 0..OC-1.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst  in  1  asynchronous, active-high reset.
- s_axis_features_tdata  in  IN_WIDTH  signed feature.
- s_axis_features_tvalid  in  1  input valid.
- s_axis_features_tready  out  1  input ready.
- s_axis_features_tlast  in  1  last beat of a frame.
- m_axis_act_tdata  out  OUT_WIDTH  requantized activation.
- m_axis_act_tvalid  out  1  output valid.
- m_axis_act_tready  in  1  downstream ready.
- m_axis_act_tlast  out  1  tlast, delayed to align with data.
- cfg_we  in  1  scale-table write strobe.
- cfg_addr  in  $clog2(OC)  channel index to write.
- cfg_data  in  SCALE_WIDTH  signed scale value.
- err_misalign  out  1  sticky flag: tlast seen with channel counter != OC-1.
- err_clear  in  1  clears err_misalign.

Behaviour:
- Reset (async assert, sync deassert):
  - all valids 0; m_axis_act_tdata 0; m_axis_act_tlast 0.
  - channel counter 0; err_misalign 0.
  - every scale-table entry = 1<<SHIFT (unity), truncated to SCALE_WIDTH.
- Reset asserted mid-frame discards all in-flight beats; no partial output after release.
- Pipeline: 3 stages, S1 multiply, S2 round+shift, S3 saturate/ReLU, output register.
  - Latency from input handshake to m_axis_act_tvalid: exactly 3 cycles when not stalled.
  - Throughput: 1 beat per cycle.
- Stall rule:
  - advance = !S3_valid || m_axis_act_tready.
  - s_axis_features_tready = advance. Combinational from m_axis_act_tready is permitted.
  - All stages hold when advance = 0, and a bubble stage must still fill (bubble collapse is not required).
  - m_axis_act_tdata, m_axis_act_tvalid and m_axis_act_tlast must stay stable while tvalid=1 and tready=0.
- Channel counter:
  - increments on each accepted input beat.
  - wraps from OC-1 to 0.
  - forced to 0 after an accepted beat with tlast=1.
  - The scale is read using the counter value at acceptance.
- Misalignment:
  - accepted beat with tlast=1 and counter != OC-1 sets err_misalign.
  - err_misalign is cleared by err_clear; set wins if both occur in the same cycle.
- Arithmetic:
  - prod = in * scale, signed, IN_WIDTH+SCALE_WIDTH bits.
  - rnd = (prod + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round-half-up.
  - Saturate rnd to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The rounding add must not overflow: use one guard bit.
- Scale writes:
  - cfg_we takes effect on the next clock edge.
  - A beat accepted in the same cycle as a write to its channel uses the old scale.
  - Writes are never blocked by backpressure.
- tlast travels through the pipeline with its beat.

Optional Feature:
- Macro: FEATURE_REQUANT_RELU_EN.
- Defined: in S3, a negative saturated result is replaced by 0, so the output range is [0, 2^(OUT_WIDTH-1)-1].
- Undefined: full signed saturated range, with no ReLU logic synthesized.
- Latency is identical in both builds.

Decomposition:
- Package feature_requant_pkg:
  - default widths.
  - scale_t and chan_idx_t typedefs.
  - a sat_round function or constant helpers for the saturation bounds.
- Sub-module requant_scale_table: OC x SCALE_WIDTH register file with unity reset, 1 write port, 1 read port, read-old-on-collision.
- The pipeline, counter and error logic stay in the top.

Test Plan:
- Unity scale, SHIFT=16, inputs 5, -5, 1000, -1000 with tready=1 → outputs 5, -5, 127, -128 (-128 → 0 with FEATURE_REQUANT_RELU_EN), each exactly 3 cycles after acceptance.
- Rounding:
  - write scale[0]=0x8000 (0.5); input 3 → 2 (1.5 rounds up).
  - input -3 → -1 (-1.5 rounds toward +inf).
- Backpressure:
  - 20-beat stream with tready toggling 1,0,0,1 …
  - outputs must appear in order with no loss or duplication.
  - data must stay stable while stalled.
  - tready must deassert only while S3 is full and downstream is not ready.
- Channel cycling, OC=4:
  - scales 1,2,3,4 (×2^16); eight inputs of 10 → 10,20,30,40,10,20,30,40.
  - tlast on beat 8 keeps err_misalign=0.
  - tlast on beat 3 of the next frame sets err_misalign=1 and restarts the counter at 0.
  - err_clear then returns err_misalign to 0.
- Write collision: cfg_we to channel 2 in the same cycle a channel-2 beat is accepted → that beat uses the old scale, and the next frame's channel-2 beat uses the new scale.
- Reset mid-frame: assert ap_rst with 3 beats in flight → m_axis_act_tvalid=0 at once and the counter returns to 0; after release the first accepted beat uses scale[0].

Source files
------------

// File: rtl/feature_requant_pkg.sv
// Shared defaults, types and saturation helpers for the feature requantizer.
package feature_requant_pkg;

  localparam int unsigned DEF_IN_WIDTH    = 32;
  localparam int unsigned DEF_OUT_WIDTH   = 8;
  localparam int unsigned DEF_SCALE_WIDTH = 16;
  localparam int unsigned DEF_SHIFT       = 16;
  localparam int unsigned DEF_OC          = 128;

  typedef logic signed [DEF_SCALE_WIDTH-1:0] scale_t;
  typedef logic [$clog2(DEF_OC)-1:0]         chan_idx_t;

  // Largest value representable in a signed field of width w.
  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_scale_table.sv
// Per-channel scale register file: unity on reset, one write port, one
// asynchronous read port. A read in the same cycle as a write to the same
// entry returns the old value because the write lands on the clock edge.
module requant_scale_table
  import feature_requant_pkg::*;
#(
  parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int unsigned SHIFT       = DEF_SHIFT,
  parameter int unsigned OC          = DEF_OC
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(OC)-1:0]    i_waddr,
  input  logic [SCALE_WIDTH-1:0]   i_wdata,
  input  logic [$clog2(OC)-1:0]    i_raddr,
  output logic [SCALE_WIDTH-1:0]   o_rdata
);

  // 1.0 in the scale's fixed-point format, truncated to the field width.
  localparam logic [SCALE_WIDTH-1:0] UNITY = SCALE_WIDTH'(1) << SHIFT;

  logic [SCALE_WIDTH-1:0] r_mem [OC];

  // Table storage: reset every entry to unity, otherwise accept writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < OC; i++) begin
        r_mem[i] <= UNITY;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/feature_requantizer.sv
// Streaming requantizer: signed feature * per-channel scale, round-half-up
// arithmetic shift, saturate to OUT_WIDTH. Three register stages
// (multiply, round+shift, saturate/output) with a global stall.
// Build option: define FEATURE_REQUANT_RELU_EN to clamp negative results to 0.
module feature_requantizer
  import feature_requant_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int unsigned SHIFT       = DEF_SHIFT,
  parameter int unsigned OC          = DEF_OC
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [IN_WIDTH-1:0]     s_axis_features_tdata,
  input  logic                    s_axis_features_tvalid,
  output logic                    s_axis_features_tready,
  input  logic                    s_axis_features_tlast,
  output logic [OUT_WIDTH-1:0]    m_axis_act_tdata,
  output logic                    m_axis_act_tvalid,
  input  logic                    m_axis_act_tready,
  output logic                    m_axis_act_tlast,
  input  logic                    cfg_we,
  input  logic [$clog2(OC)-1:0]   cfg_addr,
  input  logic [SCALE_WIDTH-1:0]  cfg_data,
  output logic                    err_misalign,
  input  logic                    err_clear
);

  localparam int unsigned CW     = $clog2(OC);
  localparam int unsigned PROD_W = IN_WIDTH + SCALE_WIDTH;
  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned SUM_W  = PROD_W + 1;

  localparam logic signed [SUM_W-1:0] RND_K  = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_hi(OUT_WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_lo(OUT_WIDTH));
  localparam logic [CW-1:0]           LAST_CH = CW'(OC - 1);

  logic                     w_adv;
  logic                     w_acc;
  logic                     w_mis;
  logic [SCALE_WIDTH-1:0]   w_scale;
  logic signed [PROD_W-1:0] w_in_ext;
  logic signed [PROD_W-1:0] w_sc_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic [OUT_WIDTH-1:0]     w_sat;

  logic [CW-1:0]            r_chan;
  logic                     r_err;
  logic                     r_v1;
  logic                     r_v2;
  logic                     r_v3;
  logic                     r_l1;
  logic                     r_l2;
  logic                     r_l3;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [SUM_W-1:0]  r_rnd;
  logic [OUT_WIDTH-1:0]     r_out;

  // Whole pipeline moves together; it may move whenever the output slot is
  // empty or being drained, so bubbles are filled but not collapsed.
  assign w_adv = !r_v3 || m_axis_act_tready;
  assign w_acc = s_axis_features_tvalid && w_adv;
  assign w_mis = w_acc && s_axis_features_tlast && (r_chan != LAST_CH);

  requant_scale_table #(
    .SCALE_WIDTH (SCALE_WIDTH),
    .SHIFT       (SHIFT),
    .OC          (OC)
  ) u_scale_table (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_chan),
    .o_rdata (w_scale)
  );

  assign w_in_ext = PROD_W'($signed(s_axis_features_tdata));
  assign w_sc_ext = PROD_W'($signed(w_scale));
  assign w_prod   = w_in_ext * w_sc_ext;
  assign w_sum    = SUM_W'(r_prod) + RND_K;

  // Saturate the rounded value to the output range (optionally ReLU).
  always_comb begin
    w_sat = '0;
    if (r_rnd > SAT_HI) begin
      w_sat = OUT_WIDTH'(SAT_HI);
    end else if (r_rnd < SAT_LO) begin
      w_sat = OUT_WIDTH'(SAT_LO);
    end else begin
      w_sat = OUT_WIDTH'(r_rnd);
    end
`ifdef FEATURE_REQUANT_RELU_EN
    if (w_sat[OUT_WIDTH-1]) begin
      w_sat = '0;
    end
`endif
  end

  // Datapath stages S1 (multiply), S2 (round+shift), S3 (saturate/output).
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_l1   <= 1'b0;
      r_l2   <= 1'b0;
      r_l3   <= 1'b0;
      r_prod <= '0;
      r_rnd  <= '0;
      r_out  <= '0;
    end else if (w_adv) begin
      r_v1   <= w_acc;
      r_l1   <= w_acc && s_axis_features_tlast;
      r_prod <= w_prod;
      r_v2   <= r_v1;
      r_l2   <= r_l1;
      r_rnd  <= w_sum >>> SHIFT;
      r_v3   <= r_v2;
      r_l3   <= r_l2;
      r_out  <= w_sat;
    end
  end

  // Channel counter: steps per accepted beat, wraps, restarts after tlast.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_chan <= '0;
    end else if (w_acc) begin
      if (s_axis_features_tlast || (r_chan == LAST_CH)) begin
        r_chan <= '0;
      end else begin
        r_chan <= r_chan + CW'(1);
      end
    end
  end

  // Sticky misalignment flag; a new error takes priority over a clear.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_err <= 1'b0;
    end else if (w_mis) begin
      r_err <= 1'b1;
    end else if (err_clear) begin
      r_err <= 1'b0;
    end
  end

  assign s_axis_features_tready = w_adv;
  assign m_axis_act_tdata       = r_out;
  assign m_axis_act_tvalid      = r_v3;
  assign m_axis_act_tlast       = r_l3;
  assign err_misalign           = r_err;

endmodule

// File: tb/tb_feature_requantizer.sv
// Self-checking bench for feature_requantizer (OC=4, SCALE_WIDTH=24 so that
// unity and 0.5 scales are representable). Expected beats come from a
// behavioural model: integer product, round-half-up divide, clamp.
module tb_feature_requantizer;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int SW = 24;
  localparam int SH = 16;
  localparam int OC = 4;
  localparam int CW = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [IW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [SW-1:0] cfg_data;
  logic          err_misalign;
  logic          err_clear;

  feature_requantizer #(
    .IN_WIDTH    (IW),
    .OUT_WIDTH   (OW),
    .SCALE_WIDTH (SW),
    .SHIFT       (SH),
    .OC          (OC)
  ) dut (
    .ap_clk                 (ap_clk),
    .ap_rst                 (ap_rst),
    .s_axis_features_tdata  (s_tdata),
    .s_axis_features_tvalid (s_tvalid),
    .s_axis_features_tready (s_tready),
    .s_axis_features_tlast  (s_tlast),
    .m_axis_act_tdata       (m_tdata),
    .m_axis_act_tvalid      (m_tvalid),
    .m_axis_act_tready      (m_tready),
    .m_axis_act_tlast       (m_tlast),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_data               (cfg_data),
    .err_misalign           (err_misalign),
    .err_clear              (err_clear)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int data;
    bit last;
    int edge_no;
  } beat_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  longint sc[OC];
  int    ch = 0;
  int    edge_cnt = 0;
  int    stall_err = 0;
  int    rdy_err = 0;
  int    stall_cycles = 0;
  int    rdy_mode = 0;
  bit    prev_stall = 0;
  logic [OW-1:0] prev_data;
  logic          prev_last;

  // Reference: exact product, floor((p + 2^(SH-1)) / 2^SH), clamp to range.
  function automatic int ref_q(input longint x, input longint s);
    longint p;
    longint r;
    p = x * s;
    r = (p + (longint'(1) <<< (SH - 1))) >>> SH;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`ifdef FEATURE_REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  always @(posedge ap_clk) edge_cnt++;

  // Downstream ready pattern: steady, 1,0,0,1 repeating, or random.
  always @(posedge ap_clk) begin
    #1;
    case (rdy_mode)
      1:       m_tready = ((edge_cnt % 4) == 0) || ((edge_cnt % 4) == 3);
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
  end

  // Monitor on the falling edge: everything is stable until the next rising
  // edge, so the handshakes seen here are the ones that edge will perform.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      exp_q.delete();
      obs_q.delete();
      ch = 0;
      for (int i = 0; i < OC; i++) sc[i] = 65536;
      prev_stall = 0;
    end else begin
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
        stall_err++;
      if (s_tready !== (!m_tvalid || m_tready)) rdy_err++;
      if (s_tvalid && s_tready) begin
        exp_q.push_back('{ref_q(longint'($signed(s_tdata)), sc[ch]), s_tlast, edge_cnt + 1});
        if (s_tlast || ch == OC - 1) ch = 0;
        else ch = ch + 1;
      end
      if (m_tvalid && m_tready)
        obs_q.push_back('{int'($signed(m_tdata)), m_tlast, edge_cnt + 1});
      prev_stall = m_tvalid && !m_tready;
      if (prev_stall) stall_cycles++;
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (cfg_we) sc[cfg_addr] = longint'($signed(cfg_data));
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CW-1:0] a, input logic [SW-1:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] d, input bit last);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (s_tready) begin
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: tready=0 for 100 cycles, required 1");
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge ap_clk);
      if (obs_q.size() == exp_q.size() && !m_tvalid) break;
    end
    tick();
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) $display("FAIL reset_valid: tvalid=%b tlast=%b required 0 0", m_tvalid, m_tlast);
    else n_pass++;
    n_checks++;
    if (m_tdata !== '0) $display("FAIL reset_data: got %0h required 0", m_tdata);
    else n_pass++;
    n_checks++;
    if (err_misalign !== 1'b0) $display("FAIL reset_err: got %b required 0", err_misalign);
    else n_pass++;
    ap_rst = 1'b0;
    tick();
    n_checks++;
    if (s_tready !== 1'b1) $display("FAIL reset_ready: got %b required 1", s_tready);
    else n_pass++;
  endtask

  task automatic test_unity();
    int want[4];
    want[0] = 5;
    want[1] = -5;
    want[2] = 127;
`ifdef FEATURE_REQUANT_RELU_EN
    want[3] = 0;
`else
    want[3] = -128;
`endif
    clear_q();
    send(5, 0);
    send(-32'sd5, 0);
    send(1000, 0);
    send(-32'sd1000, 1);
    drain();
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL unity_count: got %0d beats required 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== want[i]) $display("FAIL unity_data[%0d]: got %0d required %0d", i, obs_q[i].data, want[i]);
      else n_pass++;
      n_checks++;
      if (obs_q[i].edge_no - exp_q[i].edge_no !== 3)
        $display("FAIL unity_latency[%0d]: got %0d cycles required 3", i, obs_q[i].edge_no - exp_q[i].edge_no);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() == 4 && obs_q[3].last !== 1'b1) $display("FAIL unity_tlast: got %b required 1", obs_q[3].last);
    else n_pass++;
  endtask

  task automatic test_rounding();
    int want[4];
    want[0] = 2;
`ifdef FEATURE_REQUANT_RELU_EN
    want[1] = 0;
`else
    want[1] = -1;
`endif
    want[2] = 0;
    want[3] = 0;
    clear_q();
    cfg_write(0, 24'h008000);
    cfg_write(1, 24'h008000);
    send(3, 0);
    send(-32'sd3, 0);
    send(0, 0);
    send(0, 1);
    drain();
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL round_count: got %0d beats required 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== want[i]) $display("FAIL round_data[%0d]: got %0d required %0d", i, obs_q[i].data, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int v;
    clear_q();
    for (int c = 0; c < OC; c++) begin
      v = int'($urandom_range(0, 262143)) - 131072;
      cfg_write(CW'(c), SW'(v));
    end
    for (int pass = 1; pass <= 2; pass++) begin
      rdy_mode = pass;
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 1) == 1) v = int'($urandom());
        else v = int'($urandom_range(0, 4000)) - 2000;
        send(IW'(v), (i % 4) == 3);
      end
      drain();
    end
    rdy_mode = 0;
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 40)
      $display("FAIL bp_count: got %0d beats required %0d (40 sent)", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last)
        $display("FAIL bp_beat[%0d]: got %0d/%b required %0d/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      else n_pass++;
    end
    n_checks++;
    if (stall_err !== 0) $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stall_err);
    else n_pass++;
    n_checks++;
    if (rdy_err !== 0) $display("FAIL bp_tready: %0d cycles with wrong tready, required 0", rdy_err);
    else n_pass++;
    n_checks++;
    if (stall_cycles == 0) $display("FAIL bp_exercised: got 0 stalled cycles, required >0");
    else n_pass++;
  endtask

  task automatic test_channels();
    int want[13] = '{10, 20, 30, 40, 10, 20, 30, 40, 10, 20, 30, 10, 20};
    clear_q();
    for (int c = 0; c < OC; c++) cfg_write(CW'(c), SW'((c + 1) * 65536));
    for (int i = 0; i < 8; i++) send(10, i == 7);
    n_checks++;
    if (err_misalign !== 1'b0) $display("FAIL chan_aligned_err: got %b required 0", err_misalign);
    else n_pass++;
    for (int i = 0; i < 3; i++) send(10, i == 2);
    n_checks++;
    if (err_misalign !== 1'b1) $display("FAIL chan_misalign_err: got %b required 1", err_misalign);
    else n_pass++;
    send(10, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_checks++;
    if (err_misalign !== 1'b0) $display("FAIL chan_clear: got %b required 0", err_misalign);
    else n_pass++;
    err_clear = 1'b1;
    send(10, 1);
    err_clear = 1'b0;
    n_checks++;
    if (err_misalign !== 1'b1) $display("FAIL chan_set_wins: got %b required 1", err_misalign);
    else n_pass++;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    drain();
    n_checks++;
    if (obs_q.size() != 13) $display("FAIL chan_count: got %0d beats required 13", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 13 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== want[i]) $display("FAIL chan_data[%0d]: got %0d required %0d", i, obs_q[i].data, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int want[8] = '{10, 20, 30, 40, 10, 20, 50, 40};
    clear_q();
    send(10, 0);
    send(10, 0);
    cfg_addr = 2;
    cfg_data = SW'(5 * 65536);
    cfg_we   = 1'b1;
    send(10, 0);
    cfg_we   = 1'b0;
    send(10, 1);
    for (int i = 0; i < 4; i++) send(10, i == 3);
    drain();
    n_checks++;
    if (obs_q.size() != 8) $display("FAIL coll_count: got %0d beats required 8", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== want[i]) $display("FAIL coll_data[%0d]: got %0d required %0d", i, obs_q[i].data, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    send(20, 0);
    send(21, 0);
    send(22, 0);
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0) $display("FAIL rst_mid_out: tvalid=%b data=%0d required 0 0", m_tvalid, m_tdata);
    else n_pass++;
    tick();
    tick();
    ap_rst = 1'b0;
    tick();
    cfg_write(0, SW'(2 * 65536));
    send(7, 0);
    drain();
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL rst_mid_count: got %0d beats required 1", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_q.size() > 0 && obs_q[0].data !== 14) $display("FAIL rst_mid_chan0: got %0d required 14", obs_q[0].data);
    else if (obs_q.size() > 0) n_pass++;
    else $display("FAIL rst_mid_chan0: got no beat required 14");
  endtask

  initial begin
    ap_rst    = 1'b1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    err_clear = 1'b0;
    test_reset();
    test_unity();
    test_rounding();
    test_backpressure();
    test_channels();
    test_collision();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
